// File: rtl/layer_sequencer.sv
// Time-multiplexed dense-layer sequencer: streams (input, weight) operand pairs per output
// neuron into one shared pipelined MAC datapath and writes the returned results in order.
module layer_sequencer #(
    parameter int IN_N    = 15,
    parameter int OUT_N   = 15,
    parameter int TIMEOUT = 64,
    localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int WW = (IN_N * OUT_N > 1) ? $clog2(IN_N * OUT_N) : 1,
    localparam int OW = (OUT_N > 1) ? $clog2(OUT_N) : 1,
    localparam int RW = $clog2(OUT_N + 1),
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          stall,
    output logic          op_valid,
    output logic          op_first,
    output logic          op_last,
    output logic [IW-1:0] in_addr,
    output logic [WW-1:0] w_addr,
    output logic [OW-1:0] b_addr,
    input  logic          res_valid,
    input  logic [15:0]   res_data,
    output logic          out_we,
    output logic [OW-1:0] out_addr,
    output logic [15:0]   out_data,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] j_q, j_d;
    logic [OW-1:0] o_q, o_d;
    logic [WW-1:0] w_q, w_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [OW-1:0] oaddr_q, oaddr_d;
    logic [15:0]   odata_q, odata_d;

    logic issue, last_j, last_o, all_rcvd, accept, stray;

    // Handshake: an operand pair transfers in any cycle op_valid=1 (op_valid is already
    // gated by stall); a result transfers in any cycle res_valid=1, there is no backpressure.
    assign issue    = (state_q == S_ISSUE) && !stall;
    assign last_j   = (j_q == IW'(IN_N - 1));
    assign last_o   = (o_q == OW'(OUT_N - 1));
    assign all_rcvd = (rcnt_q == RW'(OUT_N));
    assign accept   = res_valid && !all_rcvd &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign stray    = res_valid && !accept;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        o_d     = o_q;
        w_d     = w_q;
        rcnt_d  = rcnt_q;
        idle_d  = idle_q;
        err_d   = err_q;
        we_d    = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    j_d     = '0;
                    o_d     = '0;
                    w_d     = '0;
                    rcnt_d  = '0;
                    idle_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    w_d = w_q + WW'(1);
                    if (last_j) begin
                        j_d = '0;
                        if (last_o) state_d = S_DRAIN;
                        else        o_d     = o_q + OW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (all_rcvd) begin
                    state_d = S_DONE;
                end else if (res_valid) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                    // Missing results are abandoned; the layer ends with err raised.
                    if (idle_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            we_d    = 1'b1;
            oaddr_d = OW'(rcnt_q);
            odata_d = res_data;
            rcnt_d  = rcnt_q + RW'(1);
        end
        if (stray) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            j_q     <= '0;
            o_q     <= '0;
            w_q     <= '0;
            rcnt_q  <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            o_q     <= o_d;
            w_q     <= w_d;
            rcnt_q  <= rcnt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            we_q    <= we_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    assign op_valid  = issue;
    assign op_first  = issue && (j_q == '0);
    assign op_last   = issue && last_j;
    assign in_addr   = j_q;
    assign w_addr    = w_q;
    assign b_addr    = o_q;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign out_we    = we_q;
    assign out_addr  = oaddr_q;
    assign out_data  = odata_q;
    assign dbg_state = state_q;

endmodule
